// File: rtl/inv_key_schedule.sv
// AES-128 reverse key schedule: walks round keys from round 10 back to round 0,
// one key per accepted valid/ready transfer, starting from the final round key.

module rot_word (
    input  logic [0:31] din,
    output logic [0:31] dout
);
    assign dout = {din[8:31], din[0:7]};
endmodule

module sub_word (
    input  logic [0:31] din,
    output logic [0:31] dout
);
    // Forward AES S-box, entry i at bits 8*i +: 8.
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[8*int'(b) +: 8];
    endfunction

    assign dout = {sbox(din[0:7]), sbox(din[8:15]), sbox(din[16:23]), sbox(din[24:31])};
endmodule

module inv_key_schedule #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [0:127] last_key,
    output logic         key_valid,
    input  logic         key_ready,
    output logic [0:127] round_key,
    output logic [0:3]   round_idx,
    output logic         busy,
    output logic         done
);
    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [3:0] IDX_START = 4'(NR);

    state_t         state_q, state_d;
    logic [0:127]   key_q, key_d;
    logic [3:0]     idx_q, idx_d;
    logic           valid_q, valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [0:31]    a, b, c, d;
    logic [0:31]    d_prev, rot_d, sub_d;
    logic [0:127]   prev_key;

    // Rcon first byte for the round being undone (round index before decrement).
    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    assign {a, b, c, d} = key_q;
    assign d_prev = d ^ c;

    rot_word u_rot (.din(d_prev), .dout(rot_d));
    sub_word u_sub (.din(rot_d),  .dout(sub_d));

    assign prev_key = {a ^ sub_d ^ {rcon(idx_q), 24'h000000}, b ^ a, c ^ b, d_prev};

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves a latch behind.
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = EMIT;
                    key_d   = last_key;
                    idx_d   = IDX_START;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            EMIT: begin
                if (key_ready) begin
                    if (idx_q == 4'd0) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        key_d = prev_key;
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign key_valid = valid_q;
    assign round_key = key_q;
    assign round_idx = idx_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule
